seven_seg_scan_driver: RTL and testbench



---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/seven_seg_hex_decode.sv | 13 +
 rtl/seven_seg_scan_driver.sv | 145 ++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types, hex segment patterns and polarity helper for the 7-segment display blocks.
package seven_seg_pkg;

    typedef enum logic [0:0] {BLANK, SHOW} scan_state_e;

    // Active-high patterns, bit 0 = segment a .. bit 6 = segment g.
    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_polarity(input logic [6:0] pattern,
                                                input logic       active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational hex-to-7-segment decoder producing an active-high pattern.
module seven_seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_HEX[value_i];
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed N-digit hex display driver with guard blanking, PWM dimming, blink and dp.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int unsigned N_DIGITS       = 4,
    parameter int unsigned CLK_DIV        = 100000,
    parameter int unsigned GUARD          = 1000,
    parameter int unsigned BRIGHT_W       = 4,
    parameter int unsigned BLINK_SCANS    = 64,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]   digit_en_i,
    input  logic [N_DIGITS-1:0]   dp_i,
    input  logic [N_DIGITS-1:0]   blink_i,
    input  logic [BRIGHT_W-1:0]   brightness_i,
    output logic [N_DIGITS-1:0]   anode_o,
    output logic [6:0]            segments_o,
    output logic                  dp_o,
    output logic                  frame_o
);

    localparam int unsigned CNT_W   = $clog2(CLK_DIV);
    localparam int unsigned IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned BLINK_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam int unsigned PROD_W  = CNT_W + BRIGHT_W;

    scan_state_e         state_q;
    logic [CNT_W-1:0]    slot_cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [BLINK_W-1:0]  blink_cnt_q;
    logic                blink_phase_q;
    logic [3:0]          lat_val_q;
    logic                lat_en_q;
    logic                lat_dp_q;
    logic                lat_blink_q;
    logic [BRIGHT_W-1:0] lat_bright_q;

    logic [3:0]          cur_val;
    logic                cur_en;
    logic                cur_dp;
    logic                cur_blink;
    logic [BRIGHT_W-1:0] cur_bright;
    logic                slot_start;
    logic                slot_wrap;
    logic                scan_end;
    logic                show;
    logic [PROD_W-1:0]   on_cycles;
    logic                pwm_on;
    logic                lit;
    logic [6:0]          pattern;
    logic [N_DIGITS-1:0] anode_d;

    // At slot_cnt 0 the live inputs are used directly so the first cycle of a
    // slot already sees the values being latched for the rest of it.
    always_comb begin
        slot_start = (slot_cnt_q == '0);
        if (slot_start) begin
            cur_val    = digits_i[4*int'(idx_q) +: 4];
            cur_en     = digit_en_i[idx_q];
            cur_dp     = dp_i[idx_q];
            cur_blink  = blink_i[idx_q];
            cur_bright = brightness_i;
        end else begin
            cur_val    = lat_val_q;
            cur_en     = lat_en_q;
            cur_dp     = lat_dp_q;
            cur_blink  = lat_blink_q;
            cur_bright = lat_bright_q;
        end
    end

    always_comb begin
        slot_wrap = (slot_cnt_q == CNT_W'(CLK_DIV - 1));
        scan_end  = slot_wrap && (idx_q == IDX_W'(N_DIGITS - 1));
        show      = (state_q == SHOW) || (GUARD == 0);
        on_cycles = (PROD_W'(CLK_DIV - GUARD) * (PROD_W'(cur_bright) + PROD_W'(1))) >> BRIGHT_W;
        pwm_on    = PROD_W'(slot_cnt_q - CNT_W'(GUARD)) < on_cycles;
        lit       = show && cur_en && !(cur_blink && blink_phase_q) && pwm_on;
        for (int k = 0; k < int'(N_DIGITS); k++) begin
            anode_d[k] = lit && (idx_q == IDX_W'(k));
        end
    end

    seven_seg_hex_decode u_decode (
        .value_i (cur_val),
        .seg_o   (pattern)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= BLANK;
            slot_cnt_q    <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            lat_val_q     <= '0;
            lat_en_q      <= 1'b0;
            lat_dp_q      <= 1'b0;
            lat_blink_q   <= 1'b0;
            lat_bright_q  <= '0;
            anode_o       <= {N_DIGITS{AN_ACTIVE_LOW}};
            segments_o    <= seg_polarity(SEG_OFF, SEG_ACTIVE_LOW);
            dp_o          <= SEG_ACTIVE_LOW;
            frame_o       <= 1'b0;
        end else begin
            if (slot_start) begin
                lat_val_q    <= cur_val;
                lat_en_q     <= cur_en;
                lat_dp_q     <= cur_dp;
                lat_blink_q  <= cur_blink;
                lat_bright_q <= cur_bright;
            end

            if (slot_wrap) begin
                slot_cnt_q <= '0;
                idx_q      <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
                state_q    <= (GUARD == 0) ? SHOW : BLANK;
            end else begin
                slot_cnt_q <= slot_cnt_q + CNT_W'(1);
                if ((GUARD != 0) && (slot_cnt_q == CNT_W'(GUARD - 1))) begin
                    state_q <= SHOW;
                end
            end

            if (scan_end) begin
                if (blink_cnt_q == BLINK_W'(BLINK_SCANS - 1)) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
                end
            end

            anode_o    <= anode_d ^ {N_DIGITS{AN_ACTIVE_LOW}};
            segments_o <= seg_polarity(show ? pattern : SEG_OFF, SEG_ACTIVE_LOW);
            dp_o       <= (lit && cur_dp) ^ SEG_ACTIVE_LOW;
            frame_o    <= scan_end;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with a small scan geometry (4 digits, 8-cycle slots).
module tb_seven_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  digit_en;
    logic [3:0]  dp;
    logic [3:0]  blink;
    logic [3:0]  brightness;
    logic [3:0]  anode;
    logic [6:0]  segments;
    logic        dp_out;
    logic        frame;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [15:0]     digits;
        logic [3:0]      en;
        logic [3:0]      dp;
        logic [3:0]      bright;
        int              on;
        logic [3:0][6:0] seg;
    } vec_t;

    vec_t vecs[6];

    seven_seg_scan_driver #(
        .N_DIGITS       (4),
        .CLK_DIV        (8),
        .GUARD          (2),
        .BRIGHT_W       (4),
        .BLINK_SCANS    (2),
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .digits_i     (digits),
        .digit_en_i   (digit_en),
        .dp_i         (dp),
        .blink_i      (blink),
        .brightness_i (brightness),
        .anode_o      (anode),
        .segments_o   (segments),
        .dp_o         (dp_out),
        .frame_o      (frame)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [15:0] d, input logic [3:0] en, input logic [3:0] p,
                                input logic [3:0] b, input int on, input logic [3:0][6:0] seg);
        vec_t v;
        v.digits = d;
        v.en     = en;
        v.dp     = p;
        v.bright = b;
        v.on     = on;
        v.seg    = seg;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        digits     = v.digits;
        digit_en   = v.en;
        dp         = v.dp;
        brightness = v.bright;
    endtask

    task automatic wait_frame(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (frame === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            failed++;
            $display("FAIL %s frame timeout: got no frame_o want pulse within 80 cycles", tag);
        end
    endtask

    // Checks the next 32 sampled cycles as one complete scan starting at digit 0 slot 0.
    task automatic run_scan(input string tag, input logic [3:0] en_m, input logic [3:0] dp_m,
                            input int on, input logic [3:0][6:0] seg);
        int an_bad = 0, seg_bad = 0, dp_bad = 0, fr_bad = 0;
        for (int i = 0; i < 32; i++) begin
            int k = i / 8;
            int s = i % 8;
            logic [3:0] exp_an;
            logic [6:0] exp_seg;
            logic       exp_dp;
            @(negedge clk);
            exp_an  = (en_m[k] && s >= 2 && (s - 2) < on) ? ~(4'b0001 << k) : 4'hF;
            exp_seg = (s < 2) ? 7'h7F : seg[k];
            exp_dp  = (exp_an != 4'hF && dp_m[k]) ? 1'b0 : 1'b1;
            if (anode !== exp_an) an_bad++;
            if (segments !== exp_seg) seg_bad++;
            if (dp_out !== exp_dp) dp_bad++;
            if (frame !== (i == 31)) fr_bad++;
        end
        check({tag, " anode bad cycles"}, an_bad, 0);
        check({tag, " segments bad cycles"}, seg_bad, 0);
        check({tag, " dp bad cycles"}, dp_bad, 0);
        check({tag, " frame bad cycles"}, fr_bad, 0);
    endtask

    initial begin
        int bad;
        vecs[0] = mk(16'h3210, 4'hF, 4'h0, 4'd15, 6, {7'h30, 7'h24, 7'h79, 7'h40});
        vecs[1] = mk(16'h7654, 4'hF, 4'h0, 4'd7, 3, {7'h78, 7'h02, 7'h12, 7'h19});
        vecs[2] = mk(16'hBA98, 4'hF, 4'h0, 4'd0, 0, {7'h03, 7'h08, 7'h10, 7'h00});
        vecs[3] = mk(16'hFEDC, 4'b0101, 4'b0001, 4'd15, 6, {7'h0E, 7'h06, 7'h21, 7'h46});
        vecs[4] = mk(16'h0000, 4'hF, 4'hF, 4'd10, 4, {7'h40, 7'h40, 7'h40, 7'h40});
        vecs[5] = mk(16'h1111, 4'b1010, 4'b1010, 4'd3, 1, {7'h79, 7'h79, 7'h79, 7'h79});

        // Reset hold and first scans after release.
        rst   = 1'b1;
        blink = 4'h0;
        apply(vecs[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset anode c%0d", i), anode, 4'hF);
            check($sformatf("reset segments c%0d", i), segments, 7'h7F);
        end
        check("reset dp", dp_out, 1'b1);
        check("reset frame", frame, 1'b0);
        rst = 1'b0;
        run_scan("post-reset scan0", vecs[0].en, vecs[0].dp, vecs[0].on, vecs[0].seg);
        run_scan("post-reset scan1", vecs[0].en, vecs[0].dp, vecs[0].on, vecs[0].seg);

        // Table of steady-state patterns.
        for (int v = 0; v < 6; v++) begin
            apply(vecs[v]);
            wait_frame($sformatf("vec%0d", v));
            run_scan($sformatf("vec%0d", v), vecs[v].en, vecs[v].dp, vecs[v].on, vecs[v].seg);
        end

        // Mid-slot input change is held off until digit 0's next slot.
        apply(vecs[0]);
        wait_frame("midslot sync");
        wait_frame("midslot sync");
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i >= 4 && i <= 7 && segments !== 7'h40) bad++;
            if (i == 3) digits = 16'h3218;
        end
        check("midslot segments hold 0", bad, 0);
        repeat (3) @(negedge clk);
        check("midslot next slot segments 8", segments, 7'h00);
        check("midslot next slot anode", anode, 4'b1110);

        // Blink on digit 3: lit scans 0-1, dark 2-3, lit 4-5.
        @(negedge clk);
        rst = 1'b1;
        apply(vecs[0]);
        blink = 4'b1000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 6; s++) begin
            run_scan($sformatf("blink scan%0d", s), (s == 2 || s == 3) ? 4'b0111 : 4'b1111,
                     4'h0, 6, vecs[0].seg);
        end

        // Reset mid-slot (digit 2, slot_cnt 5) while blink_phase is 1.
        for (int i = 0; i <= 20; i++) @(negedge clk);
        check("pre-reset anode digit2", anode, 4'b1011);
        rst = 1'b1;
        #1;
        check("async reset anode", anode, 4'hF);
        check("async reset segments", segments, 7'h7F);
        check("async reset dp", dp_out, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        run_scan("restart scan", 4'hF, 4'h0, 6, vecs[0].seg);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
